// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings, defaults and clog2 for the UART command framer
package uart_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      CMD     = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CHK     = 3'd4,
      HOLD    = 3'd5
   } frame_state_e;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Never returns less than 1 so that single-entry limits still get a real bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// rtl/uart_sat_cnt.sv - saturating event counter, sticks at all-ones
module uart_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_frame_ctrl.sv
// rtl/uart_cmd_frame_ctrl.sv - parses SYNC/CMD/LEN/payload/CHK frames from uart_rx into held commands
module uart_cmd_frame_ctrl
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
   parameter int         MAX_LEN       = 8,
   parameter int         TIMEOUT_TICKS = 640,
   parameter int         ERR_W         = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        s_tick,
   input  logic                        rx_done_tick,
   input  logic [7:0]                  rx_data,
   output logic                        cmd_valid,
   input  logic                        cmd_ack,
   output logic [7:0]                  cmd_code,
   output logic [7:0]                  cmd_len,
   input  logic [clog2(MAX_LEN)-1:0]   rd_addr,
   output logic [7:0]                  rd_data,
   output logic                        busy,
   output logic [ERR_W-1:0]            err_chk_cnt,
   output logic [ERR_W-1:0]            err_len_cnt,
   output logic [ERR_W-1:0]            err_to_cnt,
   output logic [ERR_W-1:0]            overrun_cnt
);

   localparam int IDX_W = clog2(MAX_LEN);
   localparam int TO_W  = clog2(TIMEOUT_TICKS);

   frame_state_e     state, state_n;
   logic [7:0]       chk;
   logic [IDX_W-1:0] idx;
   logic [TO_W-1:0]  to_cnt;
   logic [7:0]       pay_buf [MAX_LEN];

   logic in_frame, to_expire, last_payload;
   logic latch_code, latch_len, wr_buf;
   logic err_len_inc, err_chk_inc, err_to_inc, ovr_inc;

   assign in_frame     = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
   // A byte arriving on the expiring tick takes priority over the timeout.
   assign to_expire    = in_frame && s_tick && !rx_done_tick && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
   assign last_payload = (8'(idx) == (cmd_len - 8'd1));

   always_ff @(posedge clk) begin
      if (!reset) state <= HUNT;
      else        state <= state_n;
   end

   always_comb begin
      state_n     = state;
      latch_code  = 1'b0;
      latch_len   = 1'b0;
      wr_buf      = 1'b0;
      err_len_inc = 1'b0;
      err_chk_inc = 1'b0;
      err_to_inc  = 1'b0;
      ovr_inc     = 1'b0;
      case (state)
         HUNT: if (rx_done_tick && (rx_data == SYNC_BYTE)) state_n = CMD;
         CMD: if (rx_done_tick) begin
            latch_code = 1'b1;
            state_n    = LEN;
         end
         LEN: if (rx_done_tick) begin
            if (rx_data > 8'(MAX_LEN)) begin
               err_len_inc = 1'b1;
               state_n     = HUNT;
            end else begin
               latch_len = 1'b1;
               state_n   = (rx_data == 8'd0) ? CHK : PAYLOAD;
            end
         end
         PAYLOAD: if (rx_done_tick) begin
            wr_buf = 1'b1;
            if (last_payload) state_n = CHK;
         end
         CHK: if (rx_done_tick) begin
            if (rx_data == chk) begin
               state_n = HOLD;
            end else begin
               err_chk_inc = 1'b1;
               state_n     = HUNT;
            end
         end
         HOLD: begin
            ovr_inc = rx_done_tick;
            if (cmd_ack) state_n = HUNT;
         end
         default: state_n = HUNT;
      endcase
      if (to_expire) begin
         err_to_inc = 1'b1;
         state_n    = HUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cmd_code <= 8'd0;
         cmd_len  <= 8'd0;
         chk      <= 8'd0;
         idx      <= '0;
         to_cnt   <= '0;
      end else begin
         if (latch_code) begin
            cmd_code <= rx_data;
            chk      <= rx_data;
         end
         if (latch_len) begin
            cmd_len <= rx_data;
            chk     <= chk ^ rx_data;
            idx     <= '0;
         end
         if (wr_buf) begin
            chk <= chk ^ rx_data;
            if (!last_payload) idx <= idx + IDX_W'(1);
         end
         if (rx_done_tick || (state_n != state)) to_cnt <= '0;
         else if (in_frame && s_tick)            to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Payload storage survives reset; only cmd_len decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (wr_buf) pay_buf[idx] <= rx_data;
   end

   assign rd_data   = pay_buf[rd_addr];
   assign cmd_valid = (state == HOLD);
   assign busy      = (state != HUNT);

   uart_sat_cnt #(.W(ERR_W)) u_err_chk (.clk(clk), .reset(reset), .inc(err_chk_inc), .clr(1'b0), .q(err_chk_cnt));
   uart_sat_cnt #(.W(ERR_W)) u_err_len (.clk(clk), .reset(reset), .inc(err_len_inc), .clr(1'b0), .q(err_len_cnt));
   uart_sat_cnt #(.W(ERR_W)) u_err_to  (.clk(clk), .reset(reset), .inc(err_to_inc),  .clr(1'b0), .q(err_to_cnt));
   uart_sat_cnt #(.W(ERR_W)) u_overrun (.clk(clk), .reset(reset), .inc(ovr_inc),     .clr(1'b0), .q(overrun_cnt));

endmodule
